// File: rtl/io_uart.sv
// io_uart: UART peripheral on the IO bus.
//
// The peripheral decodes a 16-byte window at BASE_ADDR and acknowledges every
// selected access with a one-cycle io_ready_o pulse in the cycle after the strobe.
// Bytes written to DATA are queued in a TX FIFO and sent on tx_o as 8N1 frames.
// Frames received on rx_i are deserialized into a receive holding register.
//
// Register map (offset = io_addr_i[3:2]):
//   0 DATA   : write pushes a TX byte; read pops the received byte
//   1 STATUS : {tx_full, tx_empty, rx_valid, overrun, framing_err, rx_full} in
//              bits [5:0]; writing 1 to bit 3 or bit 4 clears that flag
//   2, 3     : read as 0; writes are ignored
//
// Optional feature: when the macro UART_RX_FIFO_EN is defined, the receive
// holding register is replaced by a FIFO of 2**TX_DEPTH_LOG2 entries, and
// STATUS bit 5 reports rx_full. Without the macro, STATUS bit 5 reads 0.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   io_addr_strobe_i         one-cycle access start
//   io_read_strobe_i         read access, qualified by io_addr_strobe_i
//   io_write_strobe_i        write access, qualified by io_addr_strobe_i
//   io_addr_i[31:0]          byte address
//   io_byte_enable_i[3:0]    write lane enables
//   io_write_data_i[31:0]    write data
//   io_read_data_o[31:0]     read data; 0 outside the acknowledge cycle
//   io_ready_o               one-cycle access acknowledge
//   rx_i                     serial input, asynchronous to clk
//   tx_o                     serial output, idles high
module io_uart #(
   parameter logic [31:0] BASE_ADDR     = 32'hC0000100,
   parameter int unsigned CLK_DIV       = 417,
   parameter int unsigned TX_DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_addr_strobe_i,
   input  logic        io_read_strobe_i,
   input  logic        io_write_strobe_i,
   input  logic [31:0] io_addr_i,
   input  logic [3:0]  io_byte_enable_i,
   input  logic [31:0] io_write_data_i,
   output logic [31:0] io_read_data_o,
   output logic        io_ready_o,
   input  logic        rx_i,
   output logic        tx_o
);

   localparam int unsigned Depth = 2 ** TX_DEPTH_LOG2;
   localparam int unsigned CntW  = $clog2(CLK_DIV);
   localparam logic [CntW-1:0] BitLast  = CntW'(CLK_DIV - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'(CLK_DIV / 2 - 1);

   typedef logic [TX_DEPTH_LOG2:0] ptr_t;

   // ---------------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------------
   logic       sel;
   logic [1:0] offset;
   logic       data_wr, stat_wr, data_rd, stat_rd;

   assign sel     = io_addr_strobe_i && (io_addr_i[31:4] == BASE_ADDR[31:4]);
   assign offset  = io_addr_i[3:2];
   assign data_wr = sel && io_write_strobe_i && (offset == 2'd0) && io_byte_enable_i[0];
   assign stat_wr = sel && io_write_strobe_i && (offset == 2'd1) && io_byte_enable_i[0];
   assign data_rd = sel && io_read_strobe_i && (offset == 2'd0);
   assign stat_rd = sel && io_read_strobe_i && (offset == 2'd1);

   logic unused_bus;
   assign unused_bus = ^{io_addr_i[1:0], io_byte_enable_i[3:1], io_write_data_i[31:8]};

   // ---------------------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------------------
   logic [7:0] tx_mem_q [Depth];
   ptr_t       tx_wr_ptr_q, tx_rd_ptr_q;
   logic       tx_fifo_empty, tx_full, tx_push, tx_pop;

   assign tx_fifo_empty = (tx_wr_ptr_q == tx_rd_ptr_q);
   assign tx_full       = ((tx_wr_ptr_q - tx_rd_ptr_q) == ptr_t'(Depth));
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   assign tx_push       = data_wr && (!tx_full || tx_pop);

   always_ff @(posedge clk) begin
      if (tx_push) begin
         tx_mem_q[tx_wr_ptr_q[TX_DEPTH_LOG2-1:0]] <= io_write_data_i[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr_ptr_q <= '0;
         tx_rd_ptr_q <= '0;
      end else begin
         if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
         if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // TX FSM
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

   tx_state_e       tx_state_q, tx_state_d;
   logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]      tx_bit_q, tx_bit_d;
   logic [7:0]      tx_shift_q, tx_shift_d;
   logic            tx_empty;

   assign tx_empty = tx_fifo_empty && (tx_state_q == TxIdle);

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      tx_o       = 1'b1;
      unique case (tx_state_q)
         TxIdle: begin
            if (!tx_fifo_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_mem_q[tx_rd_ptr_q[TX_DEPTH_LOG2-1:0]];
               tx_cnt_d   = '0;
               tx_state_d = TxStart;
            end
         end
         TxStart: begin
            tx_o = 1'b0;
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TxData;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TxData: begin
            tx_o = tx_shift_q[0];
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TxStop;
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TxStop: begin
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d   = '0;
               tx_state_d = TxIdle;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // RX synchronizer and FSM
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

   logic            rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e       rx_state_q, rx_state_d;
   logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic            rx_deliver, fe_set;

   // Synchronizer flops reset high so that leaving reset is not seen as a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // The cycle the edge is seen is offset 0 of the start bit; entering RxStart
   // with a zero count makes HalfLast land on offset CLK_DIV/2.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_deliver = 1'b0;
      fe_set     = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_cnt_d   = '0;
               rx_state_d = RxStart;
            end
         end
         RxStart: begin
            if (rx_cnt_q == HalfLast) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? RxIdle : RxData;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RxData: begin
            if (rx_cnt_q == BitLast) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RxStop;
               end else begin
                  rx_bit_d = rx_bit_q + 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RxStop: begin
            if (rx_cnt_q == BitLast) begin
               rx_cnt_d   = '0;
               rx_deliver = rx_sync_q;
               fe_set     = !rx_sync_q;
               rx_state_d = RxIdle;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Receive storage
   // ---------------------------------------------------------------------------
   logic       rx_valid, rx_full_bit, ovr_set;
   logic [7:0] rx_head;

`ifdef UART_RX_FIFO_EN
   logic [7:0] rx_mem_q [Depth];
   ptr_t       rx_wr_ptr_q, rx_rd_ptr_q;
   logic       rx_full, rx_push, rx_pop;

   assign rx_valid    = (rx_wr_ptr_q != rx_rd_ptr_q);
   assign rx_full     = ((rx_wr_ptr_q - rx_rd_ptr_q) == ptr_t'(Depth));
   assign rx_full_bit = rx_full;
   assign rx_head     = rx_mem_q[rx_rd_ptr_q[TX_DEPTH_LOG2-1:0]];
   assign rx_pop      = data_rd && rx_valid;
   assign rx_push     = rx_deliver && (!rx_full || rx_pop);
   assign ovr_set     = rx_deliver && rx_full && !rx_pop;

   always_ff @(posedge clk) begin
      if (rx_push) begin
         rx_mem_q[rx_wr_ptr_q[TX_DEPTH_LOG2-1:0]] <= rx_shift_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
      end else begin
         if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
         if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
      end
   end
`else
   logic [7:0] rx_byte_q, rx_byte_d;
   logic       rx_valid_q, rx_valid_d;

   assign rx_valid    = rx_valid_q;
   assign rx_full_bit = 1'b0;
   assign rx_head     = rx_byte_q;

   // A DATA read in the delivery cycle empties the register first, so the new
   // byte is taken without flagging overrun.
   always_comb begin
      rx_byte_d  = rx_byte_q;
      rx_valid_d = rx_valid_q;
      ovr_set    = 1'b0;
      if (data_rd) rx_valid_d = 1'b0;
      if (rx_deliver) begin
         if (rx_valid_q && !data_rd) begin
            ovr_set = 1'b1;
         end else begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Sticky flags and registered read path
   // ---------------------------------------------------------------------------
   logic        overrun_q, overrun_d, fe_q, fe_d;
   logic        ready_q;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] status;

   assign status = {26'b0, rx_full_bit, fe_q, overrun_q, rx_valid, tx_empty, tx_full};

   // A new event in the same cycle as a clear wins, so it is never lost.
   always_comb begin
      overrun_d = overrun_q;
      fe_d      = fe_q;
      if (stat_wr && io_write_data_i[3]) overrun_d = 1'b0;
      if (stat_wr && io_write_data_i[4]) fe_d = 1'b0;
      if (ovr_set) overrun_d = 1'b1;
      if (fe_set)  fe_d = 1'b1;
   end

   always_comb begin
      rdata_d = '0;
      if (data_rd && rx_valid) rdata_d = {24'b0, rx_head};
      if (stat_rd) rdata_d = status;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
         fe_q      <= 1'b0;
         ready_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         overrun_q <= overrun_d;
         fe_q      <= fe_d;
         ready_q   <= sel;
         rdata_q   <= rdata_d;
      end
   end

   assign io_ready_o     = ready_q;
   assign io_read_data_o = rdata_q;

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart with CLK_DIV=4, TX_DEPTH_LOG2=2.
module tb_io_uart;

   localparam logic [31:0] Base = 32'hC0000100;
   localparam int Div   = 4;
   localparam int Depth = 4;
`ifdef UART_RX_FIFO_EN
   localparam int RxCap = Depth;
`else
   localparam int RxCap = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        io_addr_strobe, io_read_strobe, io_write_strobe;
   logic [31:0] io_addr, io_write_data, io_read_data;
   logic [3:0]  io_byte_enable;
   logic        io_ready;
   logic        rx, tx;

   io_uart #(
      .BASE_ADDR    (Base),
      .CLK_DIV      (Div),
      .TX_DEPTH_LOG2(2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .io_addr_strobe_i (io_addr_strobe),
      .io_read_strobe_i (io_read_strobe),
      .io_write_strobe_i(io_write_strobe),
      .io_addr_i        (io_addr),
      .io_byte_enable_i (io_byte_enable),
      .io_write_data_i  (io_write_data),
      .io_read_data_o   (io_read_data),
      .io_ready_o       (io_ready),
      .rx_i             (rx),
      .tx_o             (tx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_bad   = 0;
   int last_strobe_cyc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------------------------------------------------------- reference model
   logic [7:0] m_rx[$];
   bit         m_ovr, m_fe;

   function automatic logic [31:0] exp_status(input bit txe, input bit txf);
      logic full5;
`ifdef UART_RX_FIFO_EN
      full5 = (m_rx.size() == RxCap);
`else
      full5 = 1'b0;
`endif
      return {26'b0, full5, m_fe, m_ovr, m_rx.size() != 0, txe, txf};
   endfunction

   function automatic void model_frame(input logic [7:0] b, input bit good);
      if (!good) m_fe = 1;
      else if (m_rx.size() < RxCap) m_rx.push_back(b);
      else m_ovr = 1;
   endfunction

   function automatic logic [31:0] model_read();
      if (m_rx.size() == 0) return 32'h0;
      return {24'h0, m_rx.pop_front()};
   endfunction

   // ---------------------------------------------------------------- tx monitor
   logic [7:0] mon_bytes[$];
   int         mon_start[$];
   bit         mon_ok[$];

   initial begin : tx_mon
      logic [10*Div-1:0] smp;
      logic [7:0]        b;
      int                s;
      bit                ok;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && tx === 1'b0) begin
            s      = cyc;
            smp[0] = 1'b0;
            for (int i = 1; i < 10 * Div; i++) begin
               @(negedge clk);
               smp[i] = tx;
            end
            ok = 1;
            for (int c = 0; c < 10; c++)
               for (int j = 1; j < Div; j++)
                  if (smp[c*Div+j] !== smp[c*Div]) ok = 0;
            if (smp[0] !== 1'b0 || smp[9*Div] !== 1'b1) ok = 0;
            for (int i = 0; i < 8; i++) b[i] = smp[(i+1)*Div];
            mon_bytes.push_back(b);
            mon_start.push_back(s);
            mon_ok.push_back(ok);
         end
      end
   end

   // ---------------------------------------------------------------- bus helpers
   task automatic bus(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic rdy);
      io_addr_strobe  = 1'b1;
      io_read_strobe  = !wr;
      io_write_strobe = wr;
      io_addr         = addr;
      io_byte_enable  = 4'hF;
      io_write_data   = wd;
      last_strobe_cyc = cyc;
      tick(1);
      rdy             = io_ready;
      rd              = io_read_data;
      io_addr_strobe  = 1'b0;
      io_read_strobe  = 1'b0;
      io_write_strobe = 1'b0;
      io_addr         = '0;
      io_write_data   = '0;
      tick(1);
   endtask

   task automatic reg_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      logic        rdy;
      bus(0, addr, 32'h0, rd, rdy);
      check_eq({tag, "_rdy"}, rdy, 1);
      check_eq(tag, rd, exp);
   endtask

   task automatic reg_wr(input string tag, input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] rd;
      logic        rdy;
      bus(1, addr, wd, rd, rdy);
      check_eq({tag, "_rdy"}, rdy, 1);
   endtask

   task automatic wait_frames(input int n, input int bound);
      int k = 0;
      while (mon_bytes.size() < n && k < bound) begin
         tick(1);
         k++;
      end
      check_eq("tx_frame_count", mon_bytes.size(), n);
   endtask

   task automatic flush_mon();
      mon_bytes.delete();
      mon_start.delete();
      mon_ok.delete();
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(Div);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(Div);
      end
      rx = stop;
      tick(Div);
      rx = 1'b1;
      tick(6);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin : main
      logic [7:0]  b;
      logic [7:0]  burst[6];
      logic [31:0] rd;
      logic        rdy;
      int          wcyc, n;

      rst = 1'b1;
      io_addr_strobe = 0; io_read_strobe = 0; io_write_strobe = 0;
      io_addr = '0; io_byte_enable = '0; io_write_data = '0;
      rx = 1'b1;
      tick(3);
      check_eq("rst_tx", tx, 1);
      check_eq("rst_ready", io_ready, 0);
      check_eq("rst_rdata", io_read_data, 0);
      rst = 1'b0;
      tick(1);
      reg_rd("st_after_rst", Base + 4, 32'h2);
      check_eq("tx_idle", tx, 1);

      // single frames: A5 first, then random bytes
      for (int t = 0; t < 3; t++) begin
         b = (t == 0) ? 8'hA5 : 8'($urandom);
         flush_mon();
         reg_wr("wr_single", Base, {24'h0, b});
         wcyc = last_strobe_cyc;
         wait_frames(1, 100);
         if (mon_bytes.size() >= 1) begin
            check_eq("tx_byte", mon_bytes[0], b);
            check_eq("tx_shape", mon_ok[0], 1);
            check_eq("tx_latency", mon_start[0], wcyc + 2);
         end
         tick(5);
         reg_rd("st_tx_done", Base + 4, exp_status(1, 0));
      end

      // burst of Depth+2 writes: first is popped at once, FIFO fills, last dropped
      flush_mon();
      for (int i = 0; i < 6; i++) begin
         burst[i] = 8'($urandom);
         reg_wr("wr_burst", Base, {24'h0, burst[i]});
         if (i == 3) reg_rd("st_pre_full", Base + 4, exp_status(0, 0));
         if (i == 4) reg_rd("st_full", Base + 4, exp_status(0, 1));
      end
      wait_frames(5, 400);
      for (int k = 0; k < 5 && k < mon_bytes.size(); k++) begin
         check_eq("burst_byte", mon_bytes[k], burst[k]);
         check_eq("burst_shape", mon_ok[k], 1);
         if (k > 0) check_eq("burst_gap", mon_start[k] - mon_start[k-1], 10 * Div + 1);
      end
      tick(60);
      check_eq("burst_dropped", mon_bytes.size(), 5);
      reg_rd("st_burst_done", Base + 4, exp_status(1, 0));
      flush_mon();

      // RX: 3C, then random frame counts without reading
      send_rx(8'h3C, 1);
      model_frame(8'h3C, 1);
      reg_rd("st_rx1", Base + 4, exp_status(1, 0));
      reg_rd("rx_data1", Base, model_read());
      reg_rd("st_rx1_after", Base + 4, exp_status(1, 0));
      for (int r = 0; r < 4; r++) begin
         n = (r == 0) ? 2 : $urandom_range(1, 3);
         for (int f = 0; f < n; f++) begin
            b = (r == 0) ? ((f == 0) ? 8'h11 : 8'h22) : 8'($urandom);
            send_rx(b, 1);
            model_frame(b, 1);
         end
         reg_rd("st_rx_multi", Base + 4, exp_status(1, 0));
         while (m_rx.size() != 0) reg_rd("rx_data_multi", Base, model_read());
         reg_rd("rx_data_empty", Base, model_read());
         reg_rd("st_rx_drained", Base + 4, exp_status(1, 0));
         reg_wr("clr_ovr", Base + 4, 32'h8);
         m_ovr = 0;
         reg_rd("st_ovr_clr", Base + 4, exp_status(1, 0));
      end

      // glitch, then framing error
      rx = 1'b0;
      tick(1);
      rx = 1'b1;
      tick(20);
      reg_rd("st_glitch", Base + 4, exp_status(1, 0));
      b = 8'($urandom);
      send_rx(b, 0);
      model_frame(b, 0);
      reg_rd("st_framing", Base + 4, exp_status(1, 0));
      reg_rd("rx_data_fe", Base, model_read());
      reg_wr("clr_fe", Base + 4, 32'h10);
      m_fe = 0;
      reg_rd("st_fe_clr", Base + 4, exp_status(1, 0));

      // unused offsets and unselected accesses
      reg_rd("rd_off2", Base + 8, 32'h0);
      reg_wr("wr_off3", Base + 12, 32'hFFFF_FFFF);
      bus(1, Base + 32'h10, 32'h55, rd, rdy);
      check_eq("unsel_wr_rdy", rdy, 0);
      bus(0, Base + 32'h14, 32'h0, rd, rdy);
      check_eq("unsel_rd_rdy", rdy, 0);
      check_eq("unsel_rd_data", rd, 0);
      tick(60);
      check_eq("unsel_no_tx", mon_bytes.size(), 0);
      reg_rd("st_unsel", Base + 4, exp_status(1, 0));

      // reset in the middle of a frame
      reg_wr("wr_abort", Base, 32'h00);
      tick(15);
      check_eq("tx_busy", tx, 0);
      rst = 1'b1;
      tick(1);
      check_eq("tx_abort", tx, 1);
      rst = 1'b0;
      tick(60);
      flush_mon();
      m_rx.delete();
      m_ovr = 0;
      m_fe  = 0;
      reg_rd("st_after_abort", Base + 4, exp_status(1, 0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
